// File: rtl/mul_share_pkg.sv
// Shared defaults, in-flight record and round-robin helper for the shared multiplier.
package mul_share_pkg;
  localparam int MS_W   = 32;
  localparam int MS_N   = 4;
  localparam int MS_LAT = 2;
  localparam int MS_IDW = $clog2(MS_N);

  // In-flight record at default widths; stage 1 uses a/b, later stages use product.
  typedef struct packed {
    logic                  vld;
    logic [MS_IDW-1:0]     id;
    logic [MS_W-1:0]       a;
    logic [MS_W-1:0]       b;
    logic [2*MS_W-1:0]     product;
  } pipe_rec_t;

  function automatic int next_rr_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer with wrap, pointer moves past each grant.
module rr_arbiter
  import mul_share_pkg::*;
#(
  parameter  int N   = MS_N,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  input  logic           enable,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx
);
  logic [IDW-1:0] r_ptr;

  always_comb begin
    logic [IDW:0] j;
    logic         found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = '0;
    for (int k = 0; k < N; k++) begin
      j = {1'b0, r_ptr} + (IDW+1)'(k);
      if (j >= (IDW+1)'(N)) j = j - (IDW+1)'(N);
      if (enable && !found && req[j[IDW-1:0]]) begin
        found                 = 1'b1;
        grant[j[IDW-1:0]]     = 1'b1;
        grant_idx             = j[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ptr <= '0;
    else if (|grant) r_ptr <= IDW'(next_rr_ptr(int'(grant_idx), N));
  end
endmodule

// File: rtl/signed_mul.sv
// Signed W x W multiplier core producing the full 2W-bit product.
module signed_mul #(
  parameter int W = 32
) (
  input  logic signed [W-1:0]   i_a,
  input  logic signed [W-1:0]   i_b,
  output logic signed [2*W-1:0] o_p
);
  assign o_p = i_a * i_b;
endmodule

// File: rtl/mul_share_arbiter.sv
// One signed multiplier shared by N requesters: round-robin accept, LAT-stage pipe,
// whole-pipe stall when the result is held by the consumer.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter  int W   = MS_W,
  parameter  int N   = MS_N,
  parameter  int LAT = MS_LAT,
  localparam int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_valid,
  input  logic [N*W-1:0]   req_a,
  input  logic [N*W-1:0]   req_b,
  output logic [N-1:0]     req_ready,
  output logic             res_valid,
  output logic [IDW-1:0]   res_id,
  output logic [2*W-1:0]   res_product,
  input  logic             res_ready
);
  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
  } op_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [2*W-1:0] product;
  } res_t;

  logic                  w_adv;
  logic                  w_accept;
  logic [N-1:0]          w_grant;
  logic [IDW-1:0]        w_gidx;
  logic signed [W-1:0]   w_a_sel;
  logic signed [W-1:0]   w_b_sel;
  logic signed [2*W-1:0] w_prod;

  logic [LAT:1]          r_vld_pipe;
  op_t                   r_op;
  res_t [LAT:2]          r_res;

  assign w_adv    = !(r_vld_pipe[LAT] && !res_ready);
  assign w_accept = |w_grant;

  // Gating with rst_n keeps req_ready low while reset is held.
  rr_arbiter #(.N(N)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .enable    (w_adv && rst_n),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  always_comb begin
    w_a_sel = '0;
    w_b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (w_grant[i]) begin
        w_a_sel = req_a[i*W +: W];
        w_b_sel = req_b[i*W +: W];
      end
    end
  end

  signed_mul #(.W(W)) u_mul (
    .i_a (r_op.a),
    .i_b (r_op.b),
    .o_p (w_prod)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_op       <= '0;
      r_res      <= '0;
    end else if (w_adv) begin
      r_vld_pipe <= {r_vld_pipe[LAT-1:1], w_accept};
      if (w_accept) r_op <= '{id: w_gidx, a: w_a_sel, b: w_b_sel};
      r_res[2] <= '{id: r_op.id, product: w_prod};
      for (int s = 3; s <= LAT; s++) r_res[s] <= r_res[s-1];
    end
  end

  assign req_ready   = w_grant;
  assign res_valid   = r_vld_pipe[LAT];
  assign res_id      = r_res[LAT].id;
  assign res_product = r_res[LAT].product;
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one signed W x W multiplier between N requesters.
- Round-robin arbitration picks one requester per cycle; its operands feed a fixed-latency multiply pipeline.
- Each result returns with the requester index and supports output backpressure.
- Sits between DSP clients and the multiplier core, so the design needs only one multiplier instance.

Parameters:
- W, 32, operand width (signed two's complement).
- N, 4, number of requesters, at least 2.
- LAT, 2, cycles from accept to result valid, at least 2 (stage 1 = operand register, stages 2..LAT = product registers).
- IDW, $clog2(N), width of the requester index (derived localparam).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  N  per-requester request valid.
- req_a  input  N*W  packed operand A; requester i uses bits [i*W +: W].
- req_b  input  N*W  packed operand B, same packing as req_a.
- req_ready  output  N  one-hot grant/accept; at most one bit set.
- res_valid  output  1  result valid.
- res_id  output  IDW  index of the requester that owns the result.
- res_product  output  2*W  signed product a*b.
- res_ready  input  1  downstream accepts the result.

Behaviour:
- Reset: rst_n low asynchronously clears req_ready, res_valid, res_id, res_product, every stage valid bit and the round-robin pointer (pointer = 0).
  - Operations in flight are discarded, with no partial results.
  - The first grant after release comes from requester 0 or the next requester with req_valid set.
- Stall: adv = !(res_valid && !res_ready). When adv = 0 the whole pipeline holds, including data, ids and valid bits.
  - Pipeline bubbles are not collapsed.
- Arbitration (combinational):
  - When adv = 1, grant the first i with req_valid[i] = 1, searching ptr, ptr+1, ... with wrap modulo N.
  - req_ready[i] = 1 for that i only.
  - When adv = 0 or no request is valid, req_ready = 0.
  - req_ready depends on req_valid, the pointer and res_ready only; it does not depend on data.
- Accept: a handshake occurs when req_valid[i] && req_ready[i].
  - Stage 1 captures a, b and id = i, and sets valid.
  - The pointer becomes (i+1) mod N.
  - With no handshake the pointer holds and stage 1 loads valid = 0, provided adv = 1.
- Multiply:
  - Signed multiply of the stage-1 operands, registered into stage 2, then shifted unchanged through the remaining stages to LAT.
  - res_* are the stage-LAT registers.
- Latency: handshake at edge k gives res_valid = 1 after edge k+LAT-1, so the result is visible during cycle k+LAT, assuming no stalls. Each stall cycle adds exactly one cycle.
- Throughput: one operation per cycle with no stalls.
- Result hold: res_valid, res_id and res_product stay stable until the cycle with res_valid && res_ready.
- Arithmetic:
  - Full 2W-bit two's-complement product, no truncation or saturation.
  - (-2^(W-1)) x (-2^(W-1)) = +2^(2W-2), which is representable.
  - A zero operand gives 0; there is no negative zero.
- Fairness: a continuously asserted requester waits at most N-1 accepted operations before its grant.
- Requester obligations: a requester holds req_valid, req_a and req_b stable until its handshake. The block does not check this.
- Simultaneous events: a result drain and a new accept in the same cycle are both legal, since adv = 1.
- Stage-1 operands are not sampled while adv = 0.

Decomposition:
- Package mul_share_pkg holds:
  - the default W, N and LAT;
  - a typedef for the in-flight pipeline record (valid, id, a, b / product);
  - the function next_rr_ptr.
- Sub-module rr_arbiter #(N):
  - inputs: req, enable, clk, rst_n;
  - outputs: grant one-hot, grant_idx;
  - owns the pointer and updates it on accept.
- The multiply uses the team's signed multiplier core, instantiated with width W.

Test Plan:
1. Single request: W=8; requester 2 sends a=-3, b=7 at cycle 0 with res_ready=1 -> req_ready=4'b0100 in cycle 0; res_valid=1, res_id=2, res_product=-21 (16'hFFEB) in cycle 2.
2. Corner operands: W=8; a=-128, b=-128 -> 16'h4000. Then a=-128, b=127 -> 16'hC080. Then a=0, b=-5 -> 0.
3. Round-robin: all 4 requesters held valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id follows the same order, one result per cycle after LAT.
4. Backpressure: res_ready=0 for cycles 3-5 with requesters 0 and 1 valid -> res_* hold stable; req_ready=0 in cycles 3-5; no result is lost or duplicated; order resumes 0,1 afterwards.
5. Reset mid-operation: rst_n low for one cycle with 2 operations in flight -> all outputs 0 immediately (asynchronous); no stale result after release; first grant goes to requester 0.
6. Sparse requests: requester 3 only, then requester 1 only, then requester 3 only -> grants 3,1,3; the pointer never grants an idle requester.
